// File: rtl/noc_inject_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | noc_inject_arbiter_pkg                                                     |
// | Shared defaults, o_data field layout and reset-destination helpers.        |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
package noc_inject_arbiter_pkg;

    localparam int DEF_NUM_REQ   = 2;
    localparam int DEF_X         = 2;
    localparam int DEF_Y         = 2;
    localparam int DEF_X_SIZE    = 2;
    localparam int DEF_Y_SIZE    = 2;
    localparam int DEF_PCK_NUM   = 2;
    localparam int DEF_PAYLOAD_W = 248;

    // o_data = {payload, tag, y, x}, x in the LSBs
    function automatic int total_w(int pw, int pn, int ys, int xs);
        return pw + pn + ys + xs;
    endfunction

    function automatic int y_lsb(int xs);
        return xs;
    endfunction

    function automatic int tag_lsb(int xs, int ys);
        return xs + ys;
    endfunction

    function automatic int payload_lsb(int xs, int ys, int pn);
        return xs + ys + pn;
    endfunction

    function automatic int tag_num(int pn);
        return 1 << pn;
    endfunction

    // PE (0,0) is the injection point itself, so the sweep starts past it
    function automatic int rst_x(int x);
        return (x > 1) ? 1 : 0;
    endfunction

    function automatic int rst_y(int x);
        return (x > 1) ? 0 : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/noc_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | noc_rr_arbiter                                                             |
// | One-hot request arbiter; round-robin, or fixed priority (lowest index)     |
// | when NOC_ARB_FIXED_PRIO_EN is defined.                                     |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module noc_rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] i_req,
    output logic [NUM_REQ-1:0] o_gnt,
    input  logic               i_advance
);

`ifdef NOC_ARB_FIXED_PRIO_EN
    logic w_unused;
    assign w_unused = &{1'b0, clk, reset, i_advance};

    always_comb begin
        o_gnt = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_gnt    = '0;
                o_gnt[i] = 1'b1;
            end
        end
    end
`else
    localparam int c_ptr_w = $clog2(NUM_REQ);

    logic [c_ptr_w-1:0] r_ptr;
    logic [c_ptr_w-1:0] w_ptr_nxt;
    int                 w_idx;

    // Scan from farthest to nearest offset so the nearest requester wins
    always_comb begin
        o_gnt     = '0;
        w_ptr_nxt = r_ptr;
        w_idx     = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            w_idx = (int'(r_ptr) + i) % NUM_REQ;
            if (i_req[c_ptr_w'(w_idx)]) begin
                o_gnt                   = '0;
                o_gnt[c_ptr_w'(w_idx)]  = 1'b1;
                w_ptr_nxt               = c_ptr_w'((w_idx + 1) % NUM_REQ);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (i_advance) begin
            r_ptr <= w_ptr_nxt;
        end
    end
`endif

endmodule
`default_nettype wire

// File: rtl/noc_inject_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | noc_inject_arbiter                                                         |
// | Shares the NoC injection port among host streams, stamping each beat with  |
// | a swept x/y destination and an in-flight-tracked tag.                      |
// | Build option: NOC_ARB_FIXED_PRIO_EN selects fixed-priority arbitration.    |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module noc_inject_arbiter
    import noc_inject_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = DEF_NUM_REQ,
    parameter int X         = DEF_X,
    parameter int Y         = DEF_Y,
    parameter int X_SIZE    = DEF_X_SIZE,
    parameter int Y_SIZE    = DEF_Y_SIZE,
    parameter int PCK_NUM   = DEF_PCK_NUM,
    parameter int PAYLOAD_W = DEF_PAYLOAD_W
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic [NUM_REQ-1:0]                          i_valid,
    input  logic [NUM_REQ*PAYLOAD_W-1:0]                i_data,
    output logic [NUM_REQ-1:0]                          o_ready,
    output logic                                        o_valid,
    output logic [PAYLOAD_W+PCK_NUM+Y_SIZE+X_SIZE-1:0]  o_data,
    input  logic                                        i_ready,
    input  logic                                        i_ret_valid,
    input  logic [PCK_NUM-1:0]                          i_ret_tag,
    output logic [PCK_NUM:0]                            o_outstanding,
    output logic                                        o_tag_err
);

    localparam int                c_total_w = total_w(PAYLOAD_W, PCK_NUM, Y_SIZE, X_SIZE);
    localparam int                c_tag_num = tag_num(PCK_NUM);
    localparam logic [X_SIZE-1:0] c_rst_x   = X_SIZE'(rst_x(X));
    localparam logic [Y_SIZE-1:0] c_rst_y   = Y_SIZE'(rst_y(X));
    localparam logic [X_SIZE-1:0] c_x_last  = X_SIZE'(X - 1);
    localparam logic [Y_SIZE-1:0] c_y_last  = Y_SIZE'(Y - 1);
    localparam logic [0:0]        c_st_empty = 1'b0;
    localparam logic [0:0]        c_st_full  = 1'b1;

    logic [0:0]           r_state;
    logic [0:0]           w_state_nxt;
    logic [c_tag_num-1:0] r_in_flight;
    logic [c_tag_num-1:0] w_in_flight_nxt;
    logic [PCK_NUM-1:0]   r_tag_ctr;
    logic [PCK_NUM:0]     r_outstanding;
    logic                 r_tag_err;
    logic [X_SIZE-1:0]    r_x;
    logic [Y_SIZE-1:0]    r_y;
    logic [c_total_w-1:0] r_data;
    logic [NUM_REQ-1:0]   w_gnt;
    logic                 w_accept;
    logic                 w_fire;
    logic                 w_ret_hit;
    logic [PAYLOAD_W-1:0] w_payload;

    noc_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk       (clk),
        .reset     (reset),
        .i_req     (i_valid),
        .o_gnt     (w_gnt),
        .i_advance (w_fire)
    );

    // A busy tag at the counter stalls every stream; no search for a free tag
    assign w_accept  = ((r_state == c_st_empty) || i_ready) && !r_in_flight[r_tag_ctr];
    assign o_ready   = w_gnt & {NUM_REQ{w_accept}};
    assign w_fire    = |(i_valid & o_ready);
    assign w_ret_hit = i_ret_valid && r_in_flight[i_ret_tag];

    always_comb begin
        w_payload = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (o_ready[k]) begin
                w_payload = i_data[k*PAYLOAD_W +: PAYLOAD_W];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_empty: if (w_fire) w_state_nxt = c_st_full;
            default:    if (i_ready && !w_fire) w_state_nxt = c_st_empty;
        endcase
    end

    always_comb begin
        w_in_flight_nxt = r_in_flight;
        if (i_ret_valid) w_in_flight_nxt[i_ret_tag] = 1'b0;
        if (w_fire)      w_in_flight_nxt[r_tag_ctr] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= c_st_empty;
            r_in_flight   <= '0;
            r_tag_ctr     <= '0;
            r_outstanding <= '0;
            r_tag_err     <= 1'b0;
            r_x           <= c_rst_x;
            r_y           <= c_rst_y;
        end else begin
            r_state     <= w_state_nxt;
            r_in_flight <= w_in_flight_nxt;
            r_tag_err   <= i_ret_valid && !r_in_flight[i_ret_tag];
            case ({w_fire, w_ret_hit})
                2'b10:   r_outstanding <= r_outstanding + 1'b1;
                2'b01:   r_outstanding <= r_outstanding - 1'b1;
                default: r_outstanding <= r_outstanding;
            endcase
            if (w_fire) begin
                r_tag_ctr <= r_tag_ctr + 1'b1;
                if (r_x == c_x_last && r_y == c_y_last) begin
                    r_x <= c_rst_x;
                    r_y <= c_rst_y;
                end else if (r_x == c_x_last) begin
                    r_x <= '0;
                    r_y <= r_y + 1'b1;
                end else begin
                    r_x <= r_x + 1'b1;
                end
            end
        end
    end

    // Data register is qualified by o_valid, so it needs no reset
    always_ff @(posedge clk) begin
        if (w_fire) begin
            r_data <= {w_payload, r_tag_ctr, r_y, r_x};
        end
    end

    assign o_valid       = (r_state == c_st_full);
    assign o_data        = r_data;
    assign o_outstanding = r_outstanding;
    assign o_tag_err     = r_tag_err;

endmodule
`default_nettype wire

// File: tb/tb_noc_inject_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_noc_inject_arbiter                                                      |
// | Directed self-checking bench for noc_inject_arbiter (X=Y=2, 2 streams).    |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_noc_inject_arbiter;

    localparam int NR = 2;
    localparam int PW = 248;
    localparam int TW = PW + 2 + 2 + 2;

    logic            clk = 1'b0;
    logic            reset;
    logic [NR-1:0]   i_valid;
    logic [NR*PW-1:0] i_data;
    logic [NR-1:0]   o_ready;
    logic            o_valid;
    logic [TW-1:0]   o_data;
    logic            i_ready;
    logic            i_ret_valid;
    logic [1:0]      i_ret_tag;
    logic [2:0]      o_outstanding;
    logic            o_tag_err;

    int total = 0;
    int bad   = 0;

    int xs[4] = '{1, 0, 1, 1};
    int ys[4] = '{0, 1, 1, 0};
    logic [1:0] rr_seq[4];
    logic [1:0] rr_after_stall;
    int         first_rr_stream;
    int         after_stall_stream;

    always #5 clk = ~clk;

    noc_inject_arbiter #(
        .NUM_REQ   (NR),
        .X         (2),
        .Y         (2),
        .X_SIZE    (2),
        .Y_SIZE    (2),
        .PCK_NUM   (2),
        .PAYLOAD_W (PW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .i_valid       (i_valid),
        .i_data        (i_data),
        .o_ready       (o_ready),
        .o_valid       (o_valid),
        .o_data        (o_data),
        .i_ready       (i_ready),
        .i_ret_valid   (i_ret_valid),
        .i_ret_tag     (i_ret_tag),
        .o_outstanding (o_outstanding),
        .o_tag_err     (o_tag_err)
    );

    function automatic logic [PW-1:0] pay(int s, int b);
        return {8'(s), 232'h0, 8'(b)};
    endfunction

    task automatic set_pay(int s, logic [PW-1:0] p);
        i_data[s*PW +: PW] = p;
    endtask

    task automatic chk(string tag, logic [255:0] obs, logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
`ifdef NOC_ARB_FIXED_PRIO_EN
        rr_seq             = '{2'b01, 2'b01, 2'b01, 2'b01};
        rr_after_stall     = 2'b01;
        first_rr_stream    = 0;
        after_stall_stream = 0;
`else
        rr_seq             = '{2'b10, 2'b01, 2'b10, 2'b01};
        rr_after_stall     = 2'b10;
        first_rr_stream    = 1;
        after_stall_stream = 1;
`endif
        reset       = 1'b1;
        i_valid     = '0;
        i_data      = '0;
        i_ready     = 1'b1;
        i_ret_valid = 1'b0;
        i_ret_tag   = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        @(negedge clk);
        chk("rst_valid", o_valid, 0);
        chk("rst_ready", o_ready, 0);
        chk("rst_outstanding", o_outstanding, 0);
        chk("rst_tag_err", o_tag_err, 0);

        // stream 0 streams beats back to back until the tag space is exhausted
        nxt();
        i_valid = 2'b01;
        set_pay(0, pay(0, 0));
        @(negedge clk);
        chk("t1_ready_first", o_ready, 2'b01);
        for (int b = 0; b < 4; b++) begin
            nxt();
            set_pay(0, pay(0, b + 1));
            @(negedge clk);
            chk("t1_valid", o_valid, 1);
            chk("t1_data", o_data, {pay(0, b), 2'(b), 2'(ys[b]), 2'(xs[b])});
            chk("t1_ready", o_ready, (b < 3) ? 2'b01 : 2'b00);
        end
        chk("t3_outstanding_full", o_outstanding, 4);

        // releasing tag 0 unblocks exactly one more grant, reusing tag 0
        nxt();
        i_ret_valid = 1'b1;
        i_ret_tag   = 2'd0;
        @(negedge clk);
        chk("t3_valid_drained", o_valid, 0);
        chk("t3_ready_still_blocked", o_ready, 2'b00);
        nxt();
        i_ret_valid = 1'b0;
        @(negedge clk);
        chk("t3_outstanding_after_ret", o_outstanding, 3);
        chk("t3_ready_unblocked", o_ready, 2'b01);
        nxt();
        i_valid = '0;
        @(negedge clk);
        chk("t3_data_tag0", o_data, {pay(0, 4), 2'd0, 2'd1, 2'd0});
        chk("t3_outstanding_refill", o_outstanding, 4);

        for (int i = 0; i < 4; i++) begin
            nxt();
            i_ret_valid = 1'b1;
            i_ret_tag   = 2'((i + 1) % 4);
        end
        nxt();
        i_ret_valid = 1'b0;
        @(negedge clk);
        chk("t5_outstanding_drained", o_outstanding, 0);
        chk("t5_no_err", o_tag_err, 0);

        // tag 3 is no longer in flight
        nxt();
        i_ret_valid = 1'b1;
        i_ret_tag   = 2'd3;
        nxt();
        i_ret_valid = 1'b0;
        @(negedge clk);
        chk("t5_tag_err_pulse", o_tag_err, 1);
        chk("t5_outstanding_unchanged", o_outstanding, 0);
        nxt();
        @(negedge clk);
        chk("t5_tag_err_single", o_tag_err, 0);

        // both streams requesting; pointer sits at 1 after stream 0's last grant
        nxt();
        set_pay(0, pay(0, 9));
        set_pay(1, pay(1, 9));
        i_valid = 2'b11;
        for (int g = 0; g < 4; g++) begin
            @(negedge clk);
            chk("t2_ready_seq", o_ready, rr_seq[g]);
            if (g == 1) chk("t2_first_data", o_data, {pay(first_rr_stream, 9), 2'd1, 2'd1, 2'd1});
            nxt();
        end
        i_ready     = 1'b0;
        i_ret_valid = 1'b1;
        i_ret_tag   = 2'd1;
        @(negedge clk);
        chk("t2_stall_ready", o_ready, 2'b00);
        chk("t2_stall_outstanding", o_outstanding, 4);
        nxt();
        i_ret_valid = 1'b0;

        // output held under back-pressure
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("t4_hold_valid", o_valid, 1);
            chk("t4_hold_data", o_data, {pay(0, 9), 2'd0, 2'd1, 2'd1});
            chk("t4_hold_ready", o_ready, 2'b00);
            nxt();
        end
        i_ready = 1'b1;
        @(negedge clk);
        chk("t4_release_ready", o_ready, rr_after_stall);
        nxt();
        i_valid = '0;
        i_ready = 1'b0;
        @(negedge clk);
        chk("t4_next_data", o_data, {pay(after_stall_stream, 9), 2'd1, 2'd0, 2'd1});
        chk("t4_next_valid", o_valid, 1);
        chk("t4_outstanding", o_outstanding, 4);

        // reset while a beat is held and tags are in flight
        nxt();
        reset = 1'b1;
        nxt();
        reset = 1'b0;
        @(negedge clk);
        chk("t6_valid_dropped", o_valid, 0);
        chk("t6_outstanding_clear", o_outstanding, 0);
        nxt();
        i_ready = 1'b1;
        set_pay(0, pay(0, 7));
        set_pay(1, pay(1, 7));
        i_valid = 2'b11;
        @(negedge clk);
        chk("t6_ready_ptr_reset", o_ready, 2'b01);
        nxt();
        i_valid = '0;
        @(negedge clk);
        chk("t6_data_fresh", o_data, {pay(0, 7), 2'd0, 2'd0, 2'd1});
        chk("t6_outstanding_one", o_outstanding, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
